// File: rtl/io_uart_pkg.sv
// Shared definitions for the io_uart peripheral: register offsets, STATUS bit
// positions, the FSM state type used by both serial engines and a divisor helper.
package io_uart_pkg;

  localparam logic [1:0] UART_REG_DATA    = 2'd0;
  localparam logic [1:0] UART_REG_STATUS  = 2'd1;
  localparam logic [1:0] UART_REG_DIVISOR = 2'd2;

  localparam int STAT_TX_FULL      = 0;
  localparam int STAT_TX_EMPTY     = 1;
  localparam int STAT_RX_VALID     = 2;
  localparam int STAT_RX_OVERRUN   = 3;
  localparam int STAT_TX_BUSY      = 4;
  localparam int STAT_RX_FRAME_ERR = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Divisors below 2 would leave no room for a mid-bit sample point.
  function automatic logic [15:0] eff_divisor(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/io_uart_sync_fifo.sv
// Single-clock FIFO with full/empty flags; a push and a pop in the same cycle
// both take effect. DEPTH must be a power of two so the pointers wrap freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    full      = (count_q == CNT_MAX);
    empty     = (count_q == {(AW+1){1'b0}});
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    dout      = mem_q[rd_ptr_q];
    mem_d     = mem_q;
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
    end else begin
      mem_d = mem_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: DATA/STATUS/DIVISOR registers on the core I/O bus,
// a FIFO-fed transmit shifter and a single-byte receive holding register.
module io_uart
  import io_uart_pkg::*;
#(
  parameter int TX_FIFO_DEPTH   = 16,
  parameter int DEFAULT_DIVISOR = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_bus_rd_en,
  input  logic        io_bus_wr_en,
  input  logic        io_bus_cs,
  input  logic [31:0] io_bus_address,
  input  logic [31:0] io_bus_wr_data,
  output logic [31:0] io_bus_rd_data,
  input  logic        uart_rx,
  output logic        uart_tx
);

  logic [1:0]  reg_sel_s;
  logic        wr_s, rd_s, data_wr_s, data_rd_s, status_wr_s;
  logic        fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0]  fifo_dout_s;
  logic [31:0] status_s;
  logic        rx_fall_s, rx_done_s, rx_ferr_s;
  logic [15:0] rx_half_s;
  logic        unused_s;

  logic [15:0] div_q, div_d;
  logic [31:0] rd_data_q, rd_data_d;

  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;

  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic        rx_ferr_q, rx_ferr_d;

  assign unused_s = ^{io_bus_address[31:4], io_bus_address[1:0], io_bus_wr_data[31:16]};
  assign io_bus_rd_data = rd_data_q;
  assign uart_tx        = tx_q;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (io_bus_wr_data[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Bus decode, divisor register and registered read mux (write wins over read).
  always_comb begin
    reg_sel_s   = io_bus_address[3:2];
    wr_s        = io_bus_cs & io_bus_wr_en;
    rd_s        = io_bus_cs & io_bus_rd_en & ~io_bus_wr_en;
    data_wr_s   = wr_s & (reg_sel_s == UART_REG_DATA);
    data_rd_s   = rd_s & (reg_sel_s == UART_REG_DATA);
    status_wr_s = wr_s & (reg_sel_s == UART_REG_STATUS);
    fifo_push_s = data_wr_s & ~fifo_full_s;
    div_d = (wr_s && reg_sel_s == UART_REG_DIVISOR) ? io_bus_wr_data[15:0] : div_q;
    status_s = 32'd0;
    status_s[STAT_TX_FULL]      = fifo_full_s;
    status_s[STAT_TX_EMPTY]     = fifo_empty_s;
    status_s[STAT_RX_VALID]     = rx_valid_q;
    status_s[STAT_RX_OVERRUN]   = rx_overrun_q;
    status_s[STAT_TX_BUSY]      = (tx_state_q != IDLE);
    status_s[STAT_RX_FRAME_ERR] = rx_ferr_q;
    rd_data_d = 32'd0;
    if (rd_s) begin
      case (reg_sel_s)
        UART_REG_DATA:    rd_data_d = rx_valid_q ? {24'd0, rx_byte_q} : 32'd0;
        UART_REG_STATUS:  rd_data_d = status_s;
        UART_REG_DIVISOR: rd_data_d = {16'd0, div_q};
        default:          rd_data_d = 32'd0;
      endcase
    end else begin
      rd_data_d = 32'd0;
    end
  end

  // TX shifter: the divisor is captured per frame; STOP chains directly into START.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    fifo_pop_s = 1'b0;
    case (tx_state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          tx_sh_d    = fifo_dout_s;
          tx_div_d   = eff_divisor(div_q);
          tx_cnt_d   = 16'd0;
          tx_state_d = START;
          tx_d       = 1'b0;
        end else begin
          tx_state_d = IDLE;
        end
      end
      START: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_state_d = DATA;
          tx_d       = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_d     = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d = 16'd0;
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            tx_sh_d    = fifo_dout_s;
            tx_div_d   = eff_divisor(div_q);
            tx_state_d = START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = IDLE;
            tx_d       = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_state_d = IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // RX sampler: first sample floor(div/2) cycles after the detected falling edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done_s  = 1'b0;
    rx_ferr_s  = 1'b0;
    rx_fall_s  = rx_prev_q & ~rx_sync2_q;
    rx_half_s  = {1'b0, rx_div_q[15:1]};
    case (rx_state_q)
      IDLE: begin
        if (rx_fall_s) begin
          rx_state_d = START;
          rx_cnt_d   = 16'd0;
          rx_div_d   = eff_divisor(div_q);
        end else begin
          rx_state_d = IDLE;
        end
      end
      START: begin
        if (rx_cnt_q == rx_half_s - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync2_q ? IDLE : DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_sh_d    = {rx_sync2_q, rx_sh_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_state_d = (rx_bit_q == 3'd7) ? STOP : DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = IDLE;
          rx_done_s  = rx_sync2_q;
          rx_ferr_s  = ~rx_sync2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // Receive holding register and sticky flags; a new event beats a same-cycle clear.
  always_comb begin
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = data_rd_s ? 1'b0 : rx_valid_q;
    rx_overrun_d = (status_wr_s && io_bus_wr_data[STAT_RX_OVERRUN]) ? 1'b0 : rx_overrun_q;
    rx_ferr_d    = (status_wr_s && io_bus_wr_data[STAT_RX_FRAME_ERR]) ? 1'b0 : rx_ferr_q;
    if (rx_done_s) begin
      if (rx_valid_q && !data_rd_s) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_byte_d  = rx_sh_q;
        rx_valid_d = 1'b1;
      end
    end else begin
      rx_ferr_d = rx_ferr_s ? 1'b1 : rx_ferr_d;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q        <= 16'(DEFAULT_DIVISOR);
      rd_data_q    <= 32'd0;
      tx_state_q   <= IDLE;
      tx_cnt_q     <= 16'd0;
      tx_div_q     <= 16'd2;
      tx_bit_q     <= 3'd0;
      tx_sh_q      <= 8'd0;
      tx_q         <= 1'b1;
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= IDLE;
      rx_cnt_q     <= 16'd0;
      rx_div_q     <= 16'd2;
      rx_bit_q     <= 3'd0;
      rx_sh_q      <= 8'd0;
      rx_byte_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      div_q        <= div_d;
      rd_data_q    <= rd_data_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_div_q     <= tx_div_d;
      tx_bit_q     <= tx_bit_d;
      tx_sh_q      <= tx_sh_d;
      tx_q         <= tx_d;
      rx_sync1_q   <= uart_rx;
      rx_sync2_q   <= rx_sync1_q;
      rx_prev_q    <= rx_sync2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_bit_q     <= rx_bit_d;
      rx_sh_q      <= rx_sh_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      rx_ferr_q    <= rx_ferr_d;
    end
  end

endmodule
